// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC pair-processing blocks.
package tdc_pkg;

   // Pair operation selected when word A is accepted.
   typedef enum logic [1:0] {
      MODE_PASS_B    = 2'b00,
      MODE_SUM       = 2'b01,
      MODE_B_MINUS_A = 2'b10,
      MODE_A_MINUS_B = 2'b11
   } tdc_mode_t;

   // Pairing FSM states.
   typedef enum logic [1:0] {
      WAIT_A = 2'd0,
      WAIT_B = 2'd1,
      CALC   = 2'd2
   } pair_st_t;

   // Width of the A->B timeout counter; TIMEOUT values must fit in it.
   localparam int TMO_W = 16;

endpackage

// File: rtl/tdc_pulse_stretch.sv
// Retriggerable pulse stretcher: every trig (re)loads a down-counter and the
// pulse stays high while the counter is non-zero, so PULSE_W cycles after the
// most recent trigger.
module tdc_pulse_stretch #(
   parameter int PULSE_W = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic trig,
   output logic pulse
);

   localparam int CNT_W = $clog2(PULSE_W + 1);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;

   // Reload on trigger, otherwise count down to zero.
   always_comb begin
      cnt_next = cnt_reg;
      if (trig) begin
         cnt_next = CNT_W'(PULSE_W);
      end else if (cnt_reg != '0) begin
         cnt_next = cnt_reg - CNT_W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign pulse = (cnt_reg != '0);

endmodule

// File: rtl/tdc_pair_calc.sv
// Pairs consecutive TDC words (A then B), applies the selected operation plus
// a signed offset in IN_W+2 bits, then clamps or truncates to OUT_W bits.
// Result appears two edges after B is accepted, with a stretched valid strobe.
module tdc_pair_calc
   import tdc_pkg::*;
#(
   parameter int                       IN_W     = 37,
   parameter int                       OUT_W    = 20,
   parameter logic signed [IN_W+1:0]   OFFSET   = '0,
   parameter bit                       SATURATE = 1'b1,
   parameter int unsigned              TIMEOUT  = 16'hFFFF,
   parameter int                       PULSE_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dval,
   input  logic [IN_W-1:0]  mlt,
   input  logic [1:0]       mode,
   output logic [OUT_W-1:0] out_data,
   output logic             o_dval,
   output logic             o_sat,
   output logic             o_drop
);

   localparam int R_W = IN_W + 2;

   // Last count value before the pending A is abandoned.
   localparam logic [TMO_W-1:0] TMO_LAST =
      (TIMEOUT == 0) ? {TMO_W{1'b0}} : TMO_W'(TIMEOUT - 1);

   // Largest representable output, expressed in the wide signed domain.
   localparam logic signed [R_W-1:0] OUT_MAX =
      $signed({{(R_W - OUT_W){1'b0}}, {OUT_W{1'b1}}});

   pair_st_t               state_reg,    state_next;
   logic [IN_W-1:0]        a_reg,        a_next;
   logic [IN_W-1:0]        b_reg,        b_next;
   tdc_mode_t              mode_reg,     mode_next;
   logic [TMO_W-1:0]       tmo_cnt_reg,  tmo_cnt_next;
   logic signed [R_W-1:0]  r_reg,        r_next;
   logic                   r_vld_reg,    r_vld_next;
   logic                   drop_reg,     drop_next;
   logic [OUT_W-1:0]       out_data_reg;
   logic                   sat_reg;

   logic signed [R_W-1:0]  a_s;
   logic signed [R_W-1:0]  b_s;
   logic signed [R_W-1:0]  op_s;
   logic [OUT_W-1:0]       clamp_data;
   logic                   clamp_sat;

   assign a_s = $signed({2'b00, a_reg});
   assign b_s = $signed({2'b00, b_reg});

   // Selected pair operation on the latched words, using the mode captured with A.
   always_comb begin
      op_s = b_s;
      case (mode_reg)
         MODE_PASS_B:    op_s = b_s;
         MODE_SUM:       op_s = a_s + b_s;
         MODE_B_MINUS_A: op_s = b_s - a_s;
         MODE_A_MINUS_B: op_s = a_s - b_s;
         default:        op_s = b_s;
      endcase
   end

   // Pairing FSM: a word seen in CALC starts the next pair so nothing is lost.
   always_comb begin
      state_next   = state_reg;
      a_next       = a_reg;
      b_next       = b_reg;
      mode_next    = mode_reg;
      tmo_cnt_next = tmo_cnt_reg;
      r_next       = r_reg;
      r_vld_next   = 1'b0;
      drop_next    = 1'b0;
      case (state_reg)
         WAIT_A: begin
            if (dval) begin
               a_next       = mlt;
               mode_next    = tdc_mode_t'(mode);
               tmo_cnt_next = '0;
               state_next   = WAIT_B;
            end
         end
         WAIT_B: begin
            if (dval) begin
               b_next     = mlt;
               state_next = CALC;
            end else if ((TIMEOUT != 0) && (tmo_cnt_reg == TMO_LAST)) begin
               drop_next  = 1'b1;
               state_next = WAIT_A;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
            end
         end
         CALC: begin
            r_next     = op_s + OFFSET;
            r_vld_next = 1'b1;
            if (dval) begin
               a_next       = mlt;
               mode_next    = tdc_mode_t'(mode);
               tmo_cnt_next = '0;
               state_next   = WAIT_B;
            end else begin
               state_next = WAIT_A;
            end
         end
         default: begin
            state_next = WAIT_A;
         end
      endcase
   end

   // Clamp (or plain truncation) of the wide result to the output width.
   always_comb begin
      clamp_data = r_reg[OUT_W-1:0];
      clamp_sat  = 1'b0;
      if (SATURATE) begin
         if (r_reg < 0) begin
            clamp_data = '0;
            clamp_sat  = 1'b1;
         end else if (r_reg > OUT_MAX) begin
            clamp_data = '1;
            clamp_sat  = 1'b1;
         end
      end
   end

   // FSM, operand buffers and wide result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= WAIT_A;
         a_reg       <= '0;
         b_reg       <= '0;
         mode_reg    <= MODE_PASS_B;
         tmo_cnt_reg <= '0;
         r_reg       <= '0;
         r_vld_reg   <= 1'b0;
         drop_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         a_reg       <= a_next;
         b_reg       <= b_next;
         mode_reg    <= mode_next;
         tmo_cnt_reg <= tmo_cnt_next;
         r_reg       <= r_next;
         r_vld_reg   <= r_vld_next;
         drop_reg    <= drop_next;
      end
   end

   // Output stage: result and clamp flag held until the next result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_data_reg <= '0;
         sat_reg      <= 1'b0;
      end else if (r_vld_reg) begin
         out_data_reg <= clamp_data;
         sat_reg      <= clamp_sat;
      end
   end

   // Valid strobe starts on the same edge as the output update.
   tdc_pulse_stretch #(
      .PULSE_W (PULSE_W)
   ) u_pulse (
      .clk   (clk),
      .rst   (rst),
      .trig  (r_vld_reg),
      .pulse (o_dval)
   );

   assign out_data = out_data_reg;
   assign o_sat    = sat_reg;
   assign o_drop   = drop_reg;

endmodule
